aq_gemac_tx_arbiter: RTL

- Frame-level round-robin arbiter sharing the single GEMAC TX buffer write port (TX_BUFF_WE/START/END/DATA, READY/FULL/SPACE) between two frame sources, e.g. the UDP loop engine and a CPU/ARP frame writer.
- Grants only when the TX buffer has room for the whole requested frame.
- Holds the grant from frame start to frame end, so frames never interleave.
- Sits between the requesters and aq_gemac_ipctrl, in the system clock domain.

---
 rtl/aq_gemac_tx_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/aq_gemac_tx_arbiter.sv
// Frame-level round-robin arbiter for the single GEMAC TX buffer write port, shared by two frame sources.
// Optional idle-write watchdog enabled by defining AQ_GEMAC_TX_ARB_TIMEOUT_EN.
module aq_gemac_tx_arbiter #(
    parameter int SPACE_W        = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               REQ0,
    input  logic               REQ1,
    input  logic [SPACE_W-1:0] LEN0,
    input  logic [SPACE_W-1:0] LEN1,
    output logic               GNT0,
    output logic               GNT1,
    input  logic               WE0,
    input  logic               WE1,
    input  logic               START0,
    input  logic               START1,
    input  logic               END0,
    input  logic               END1,
    input  logic [31:0]        DATA0,
    input  logic [31:0]        DATA1,
    output logic               TX_BUFF_WE,
    output logic               TX_BUFF_START,
    output logic               TX_BUFF_END,
    output logic [31:0]        TX_BUFF_DATA,
    input  logic               TX_BUFF_READY,
    input  logic               TX_BUFF_FULL,
    input  logic [SPACE_W-1:0] TX_BUFF_SPACE,
    output logic               ERR,
    output logic               LAST_GNT
);

    localparam int DATA_W = 32;
    localparam logic [SPACE_W:0] CNT_ONE = (SPACE_W+1)'(1);

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state;
    state_t              state_nxt;

    logic                gnt_vld;
    logic                gnt_sel;
    logic                last_gnt;
    logic [SPACE_W-1:0]  len_lat;
    logic [SPACE_W-1:0]  word_cnt;

    logic                tx_we_p1;
    logic                tx_start_p1;
    logic                tx_end_p1;
    logic [DATA_W-1:0]   tx_data_p1;
    logic                err_p1;

    logic                cand;
    logic                cand_req;
    logic [SPACE_W-1:0]  cand_len;
    logic                arb_en;
    logic                grant;
    logic                len_err;
    logic                g_we;
    logic                g_start;
    logic                g_end;
    logic [DATA_W-1:0]   g_data;
    logic                o_we;
    logic                wr_fwd;
    logic                frame_end;
    logic [SPACE_W:0]    cnt_inc;
    logic                err_nxt;
    logic                timeout_fire;

`ifdef AQ_GEMAC_TX_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_fire = (state == BUSY) && !g_we && (idle_cnt == IDLE_LIMIT);

    // Watchdog: cycles spent in BUSY since the last granted write.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            idle_cnt <= '0;
        end else if (state != BUSY || g_we) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_ONE;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    if (frame_end || timeout_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration, write steering and error detection
    always_comb begin
        cand      = 1'b0;
        cand_req  = REQ0 | REQ1;
        cand_len  = LEN0;
        arb_en    = 1'b0;
        grant     = 1'b0;
        len_err   = 1'b0;
        g_we      = 1'b0;
        g_start   = 1'b0;
        g_end     = 1'b0;
        g_data    = DATA0;
        o_we      = 1'b0;
        wr_fwd    = 1'b0;
        frame_end = 1'b0;
        cnt_inc   = {1'b0, word_cnt} + CNT_ONE;
        err_nxt   = 1'b0;

        if (REQ0 && REQ1) begin
            cand = ~last_gnt;
        end else begin
            cand = REQ1;
        end
        cand_len = cand ? LEN1 : LEN0;

        // Hold off arbitration during the grant-release cycle after a frame.
        arb_en  = (state == IDLE) && !gnt_vld && cand_req;
        len_err = arb_en && (cand_len == '0);
        grant   = arb_en && (cand_len != '0) && (cand_len <= TX_BUFF_SPACE) && TX_BUFF_READY;

        if (gnt_sel) begin
            g_we    = WE1;
            g_start = START1;
            g_end   = END1;
            g_data  = DATA1;
            o_we    = WE0;
        end else begin
            g_we    = WE0;
            g_start = START0;
            g_end   = END0;
            g_data  = DATA0;
            o_we    = WE1;
        end

        wr_fwd    = (state == BUSY) && g_we;
        frame_end = wr_fwd && g_end;

        err_nxt = len_err
                | ((state == BUSY) && o_we)
                | ((state == IDLE) && (WE0 || WE1))
                | (wr_fwd && TX_BUFF_FULL)
                | (wr_fwd && (cnt_inc > {1'b0, len_lat}))
                | (wr_fwd && g_start && (word_cnt != '0))
                | timeout_fire;
    end

    // Grant and frame bookkeeping
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            gnt_vld  <= 1'b0;
            gnt_sel  <= 1'b0;
            last_gnt <= 1'b1;
            len_lat  <= '0;
            word_cnt <= '0;
        end else begin
            if (grant) begin
                gnt_vld  <= 1'b1;
                gnt_sel  <= cand;
                last_gnt <= cand;
                len_lat  <= cand_len;
                word_cnt <= '0;
            end else if (len_err) begin
                last_gnt <= cand;
            end else if (state == IDLE && gnt_vld) begin
                gnt_vld <= 1'b0;
            end

            if (wr_fwd && (word_cnt != '1)) begin
                word_cnt <= cnt_inc[SPACE_W-1:0];
            end
        end
    end

    // Output stage p1: forwarded write and error pulse, one cycle behind the requester
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tx_we_p1    <= 1'b0;
            tx_start_p1 <= 1'b0;
            tx_end_p1   <= 1'b0;
            tx_data_p1  <= '0;
            err_p1      <= 1'b0;
        end else begin
            err_p1 <= err_nxt;
            if (wr_fwd) begin
                tx_we_p1    <= 1'b1;
                tx_start_p1 <= g_start;
                tx_end_p1   <= g_end;
                tx_data_p1  <= g_data;
            end else if (timeout_fire) begin
                tx_we_p1    <= 1'b1;
                tx_start_p1 <= 1'b0;
                tx_end_p1   <= 1'b1;
                tx_data_p1  <= '0;
            end else begin
                tx_we_p1    <= 1'b0;
                tx_start_p1 <= 1'b0;
                tx_end_p1   <= 1'b0;
            end
        end
    end

    assign GNT0          = gnt_vld & ~gnt_sel;
    assign GNT1          = gnt_vld &  gnt_sel;
    assign LAST_GNT      = last_gnt;
    assign ERR           = err_p1;
    assign TX_BUFF_WE    = tx_we_p1;
    assign TX_BUFF_START = tx_start_p1;
    assign TX_BUFF_END   = tx_end_p1;
    assign TX_BUFF_DATA  = tx_data_p1;

endmodule
